divider_restoring: RTL and testbench

//   Multi-cycle unsigned integer divider using restoring shift-subtract.

---
 rtl/divider_restoring.sv | 137 +++++++++++++
 tb/tb_divider_restoring.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/divider_restoring.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, with
// valid/ready handshakes on the operand and result sides.

module AddSub_Structural #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub_add,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] carry;

    // Subtraction is a + ~b + 1: invert b and inject the +1 as the first carry.
    assign b_eff    = b ^ {WIDTH{sub_add}};
    assign carry[0] = carry_in ^ sub_add;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i] = a[i] ^ b_eff[i] ^ carry[i];
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
    end
endmodule

module divider_restoring #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] A,
    input  logic [WORD_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] quotient,
    output logic [WORD_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);
    localparam int CW = $clog2(WORD_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [WORD_WIDTH-1:0] rem_q, quo_q, divisor;
    logic [CW-1:0]         count;
    logic                  dbz_q;
    logic [WORD_WIDTH-1:0] rem_shift, quo_shift;
    logic [WORD_WIDTH:0]   trial;

    assign rem_shift = {rem_q[WORD_WIDTH-2:0], quo_q[WORD_WIDTH-1]};
    assign quo_shift = {quo_q[WORD_WIDTH-2:0], 1'b0};

    // One extra bit so the MSB of the difference acts as the borrow/sign.
    AddSub_Structural #(.WIDTH(WORD_WIDTH + 1)) u_trial (
        .a        ({1'b0, rem_shift}),
        .b        ({1'b0, divisor}),
        .sub_add  (1'b1),
        .carry_in (1'b0),
        .sum      (trial)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (B == '0) ? DONE : CALC;
            end
            CALC: begin
                if (count == '0) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            divisor <= '0;
            count   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        divisor <= B;
                        if (B == '0) begin
                            quo_q <= '1;
                            rem_q <= A;
                            dbz_q <= 1'b1;
                        end else begin
                            quo_q <= A;
                            rem_q <= '0;
                            count <= CW'(WORD_WIDTH - 1);
                            dbz_q <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (!trial[WORD_WIDTH]) begin
                        rem_q <= trial[WORD_WIDTH-1:0];
                        quo_q <= quo_shift | WORD_WIDTH'(1);
                    end else begin
                        rem_q <= rem_shift;
                        quo_q <= quo_shift;
                    end
                    if (count != '0) count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_restoring.sv
// Self-checking bench for divider_restoring at WORD_WIDTH = 8, using plain
// integer division as the reference.

module tb_divider_restoring;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid, in_ready;
    logic [W-1:0] A, B;
    logic         out_valid, out_ready;
    logic [W-1:0] quotient, remainder;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    divider_restoring #(.WORD_WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for the result, optionally stall the
    // consumer for 'hold' cycles, then take the result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          output logic [W-1:0] q_obs, output logic [W-1:0] r_obs);
        logic [W-1:0] eq, er;
        logic         edz;
        int           lat, explat;
        eq     = (b == 0) ? 8'hFF : W'(a / b);
        er     = (b == 0) ? a : W'(a % b);
        edz    = (b == 0);
        explat = (b == 0) ? 1 : W + 1;

        @(negedge clock);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        A = a;
        B = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(explat));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_by_zero", 32'(div_by_zero), 32'(edz));
        q_obs = quotient;
        r_obs = remainder;

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            A = W'($urandom);
            B = W'($urandom);
            @(posedge clock);
            #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_quotient", 32'(quotient), 32'(eq));
            check("hold_remainder", 32'(remainder), 32'(er));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_take", 32'(in_ready), 32'd1);
        check("out_valid_after_take", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] q, r, ra, rb;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op(8'd100, 8'd7, 0, q, r);
        run_op(8'd255, 8'd1, 0, q, r);
        run_op(8'd3, 8'd10, 0, q, r);
        run_op(8'd5, 8'd0, 0, q, r);
        run_op(8'd77, 8'd77, 0, q, r);
        run_op(8'd200, 8'd13, 5, q, r);
        run_op(8'd0, 8'd0, 2, q, r);

        // Reset in the middle of a computation.
        @(negedge clock);
        in_valid = 1'b1;
        A = 8'd100;
        B = 8'd7;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op(8'd9, 8'd3, 0, q, r);

        for (int n = 0; n < 2000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(1, 255));
            run_op(ra, rb, 0, q, r);
            check("invariant_qb_plus_r", 32'(q) * 32'(rb) + 32'(r), 32'(ra));
            check("invariant_r_lt_b", 32'(r < rb), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
